// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: control, imem port and decode handshake.
// DUT takes the slave modport; the environment takes master.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start_i;
  logic [31:0]   imem_addr_o;
  logic [31:0]   imem_instr_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  start_i,
    input  imem_instr_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  instr_ready_i,
    output imem_addr_o,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    output count_o
  );

  modport master (
    output start_i,
    output imem_instr_i,
    output redirect_i,
    output redirect_pc_i,
    output instr_ready_i,
    input  imem_addr_o,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    input  count_o
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner plus prefetch FIFO feeding decode,
// with flush-and-redirect for taken branches and jumps.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q;
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic not_empty;
  logic valid;
  logic pop;
  logic push;

  assign not_empty = (count_q != '0);
  assign valid     = not_empty & ~bus.redirect_i;
  assign pop       = valid & bus.instr_ready_i;
  assign push      = bus.start_i & ~bus.redirect_i
                   & ((count_q != FULL) | pop);

  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.count_o       = count_q;
  assign bus.instr_o       = not_empty ? mem_instr[head_q] : '0;
  assign bus.instr_pc_o    = not_empty ? mem_pc[head_q] : '0;

  // Storage needs no reset: empty slots are masked by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[tail_q] <= bus.imem_instr_i;
      mem_pc[tail_q]    <= pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.redirect_i) begin
      pc_q    <= {bus.redirect_pc_i[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        tail_q <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      unique case (1'b1)
        push & ~pop: count_q <= count_q + 1'b1;
        pop & ~push: count_q <= count_q - 1'b1;
        default:     count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, fill,
// redirect, drain, PC wrap and asynchronous reset.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_fetch_queue_if #(.DEPTH(4)) bus ();

  instr_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  // Combinational imem: word = 0x13 + address
  assign bus.imem_instr_i = 32'h0000_0013 + bus.imem_addr_o;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string tag,
                      input logic [31:0] pc,
                      input logic [31:0] cnt);
    chk({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd1);
    chk({tag, "_pc"}, bus.instr_pc_o, pc);
    chk({tag, "_instr"}, bus.instr_o, pc + 32'h13);
    chk({tag, "_count"}, 32'(bus.count_o), cnt);
  endtask

  task automatic empty(input string tag);
    chk({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd0);
    chk({tag, "_count"}, 32'(bus.count_o), 32'd0);
    chk({tag, "_instr"}, bus.instr_o, 32'd0);
    chk({tag, "_pc"}, bus.instr_pc_o, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b0;
    tick();
    tick();
    empty("rst");
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    rst_n = 1'b1;

    // 1: streaming with decode always ready
    bus.start_i = 1'b1;
    bus.instr_ready_i = 1'b1;
    chk("t1_pre_valid", 32'(bus.instr_valid_o), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      head("t1", 32'(4 * i), 32'd1);
      tick();
    end

    // 2: restart at 0, then fill with decode stalled
    bus.instr_ready_i = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0;
    tick();
    bus.redirect_i = 1'b0;
    chk("t2_addr0", bus.imem_addr_o, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    head("t2_full", 32'h0, 32'd4);
    chk("t2_addr16", bus.imem_addr_o, 32'd16);
    tick();
    chk("t2_frozen", bus.imem_addr_o, 32'd16);
    chk("t2_cnt4", 32'(bus.count_o), 32'd4);
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    head("t2_pp", 32'd4, 32'd4);
    chk("t2_addr20", bus.imem_addr_o, 32'd20);

    // 3: redirect with three entries queued
    bus.start_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    head("t3_q3", 32'd8, 32'd3);
    bus.start_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    bus.instr_ready_i = 1'b1;
    #1;
    chk("t3_rd_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("t3_rd_count", 32'(bus.count_o), 32'd3);
    bus.instr_ready_i = 1'b0;
    tick();
    bus.redirect_i = 1'b0;
    empty("t3_flush");
    chk("t3_addr", bus.imem_addr_o, 32'h100);
    tick();
    head("t3_new", 32'h100, 32'd1);
    bus.instr_ready_i = 1'b1;
    tick();
    head("t3_next", 32'h104, 32'd1);

    // 4: stop fetching and drain two entries
    bus.instr_ready_i = 1'b0;
    tick();
    head("t4_q2", 32'h104, 32'd2);
    bus.start_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    tick();
    head("t4_pop1", 32'h108, 32'd1);
    tick();
    empty("t4_empty");
    chk("t4_addr", bus.imem_addr_o, 32'h10C);
    tick();
    empty("t4_under");
    chk("t4_addr2", bus.imem_addr_o, 32'h10C);

    // 5: fetch PC wraps through zero
    bus.instr_ready_i = 1'b0;
    bus.start_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    head("t5_a", 32'hFFFF_FFF8, 32'd3);
    chk("t5_addr", bus.imem_addr_o, 32'd4);
    bus.start_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    tick();
    head("t5_b", 32'hFFFF_FFFC, 32'd2);
    tick();
    head("t5_c", 32'h0, 32'd1);
    tick();
    empty("t5_end");

    // 6: async reset with full queue and redirect pending
    bus.instr_ready_i = 1'b0;
    bus.start_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    head("t6_full", 32'd4, 32'd4);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    #2;
    rst_n = 1'b0;
    #1;
    empty("t6_async");
    chk("t6_addr", bus.imem_addr_o, 32'h0);
    @(negedge clk);
    bus.redirect_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    rst_n = 1'b1;
    tick();
    head("t6_restart", 32'h0, 32'd1);
    chk("t6_addr4", bus.imem_addr_o, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
